// File: rtl/vga_sprite_compositor.sv
// VGA 640x480 timing generator with a 1-bit background bitmap and NUM_SPRITES
// frame-synchronous, animated 1-bit sprites. The pipeline runs two pixel ticks from counters to pins.
module vga_sprite_compositor #(
    parameter int CLK_DIV     = 4,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int NUM_SPRITES = 2,
    parameter int SPRITE_W    = 60,
    parameter int SPRITE_H    = 60,
    parameter int NUM_FRAMES  = 3,
    parameter int COLOR_W     = 12,
    parameter int SADDR_W     = $clog2(SPRITE_W*SPRITE_H*NUM_FRAMES),
    parameter int BADDR_W     = $clog2(H_ACTIVE*V_ACTIVE)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SPRITES*10-1:0]      sprite_x,
    input  logic [NUM_SPRITES*9-1:0]       sprite_y,
    input  logic [NUM_SPRITES-1:0]         sprite_en,
    input  logic [NUM_SPRITES*2-1:0]       sprite_frame,
    input  logic [NUM_SPRITES*COLOR_W-1:0] sprite_color,
    input  logic [COLOR_W-1:0]             bg_ink,
    input  logic [COLOR_W-1:0]             bg_paper,
    output logic [BADDR_W-1:0]             bg_addr,
    input  logic                           bg_data,
    output logic [NUM_SPRITES*SADDR_W-1:0] spr_addr,
    input  logic [NUM_SPRITES-1:0]         spr_data,
    output logic                           hSync,
    output logic                           vSync,
    output logic [3:0]                     VGA_R,
    output logic [3:0]                     VGA_G,
    output logic [3:0]                     VGA_B,
    output logic                           active,
    output logic                           screenEnd
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [9:0]       hcount;
    logic [9:0]       vcount;
    logic             h_last;
    logic             v_last;
    logic             frame_wrap;

    assign tick       = (div == DIV_W'(CLK_DIV - 1));
    assign h_last     = (hcount == 10'(H_TOTAL - 1));
    assign v_last     = (vcount == 10'(V_TOTAL - 1));
    assign frame_wrap = tick && h_last && v_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            div       <= '0;
            hcount    <= '0;
            vcount    <= '0;
            screenEnd <= 1'b0;
        end else begin
            screenEnd <= frame_wrap;
            div       <= tick ? '0 : div + DIV_W'(1);
            if (tick) begin
                if (h_last) begin
                    hcount <= '0;
                    vcount <= v_last ? '0 : vcount + 10'd1;
                end else begin
                    hcount <= hcount + 10'd1;
                end
            end
        end
    end

    // Sprite state seen by the pipeline; reloaded only at the frame boundary so a frame never tears.
    logic [9:0]         sh_x     [NUM_SPRITES];
    logic [8:0]         sh_y     [NUM_SPRITES];
    logic [1:0]         sh_frame [NUM_SPRITES];
    logic [COLOR_W-1:0] sh_color [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] sh_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_en <= '0;
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                sh_x[i]     <= '0;
                sh_y[i]     <= '0;
                sh_frame[i] <= '0;
                sh_color[i] <= '0;
            end
        end else if (screenEnd) begin
            sh_en <= sprite_en;
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                sh_x[i]     <= sprite_x[10*i +: 10];
                sh_y[i]     <= sprite_y[9*i +: 9];
                sh_color[i] <= sprite_color[COLOR_W*i +: COLOR_W];
                sh_frame[i] <= ({30'd0, sprite_frame[2*i +: 2]} >= 32'(NUM_FRAMES))
                               ? 2'd0 : sprite_frame[2*i +: 2];
            end
        end
    end

    logic                   vis0;
    logic                   hs0;
    logic                   vs0;
    logic [NUM_SPRITES-1:0] hit_c;
    logic [SADDR_W-1:0]     addr_c [NUM_SPRITES];
    logic [BADDR_W-1:0]     bg_off;

    assign vis0   = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
    assign hs0    = !((hcount >= 10'(HS_START)) && (hcount <= 10'(HS_END)));
    assign vs0    = !((vcount >= 10'(VS_START)) && (vcount <= 10'(VS_END)));
    assign bg_off = BADDR_W'(hcount) + BADDR_W'(vcount) * BADDR_W'(H_ACTIVE);

    // Widened compares keep a sprite near the right/bottom edge from wrapping back onto column/row 0.
    always_comb begin
        hit_c = '0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            hit_c[i] = sh_en[i] && vis0
                       && ({1'b0, hcount} >= {1'b0, sh_x[i]})
                       && ({1'b0, hcount} <  ({1'b0, sh_x[i]} + 11'(SPRITE_W)))
                       && (vcount >= {1'b0, sh_y[i]})
                       && (vcount <  ({1'b0, sh_y[i]} + 10'(SPRITE_H)));
            addr_c[i] = '0;
            if (hit_c[i]) begin
                addr_c[i] = SADDR_W'(sh_frame[i]) * SADDR_W'(SPRITE_W*SPRITE_H)
                          + SADDR_W'(vcount - {1'b0, sh_y[i]}) * SADDR_W'(SPRITE_W)
                          + SADDR_W'(hcount - sh_x[i]);
            end
        end
    end

    logic [NUM_SPRITES-1:0] hit1;
    logic                   vis1;
    logic                   hs1;
    logic                   vs1;

    always_ff @(posedge clk) begin
        if (reset) begin
            bg_addr  <= '0;
            spr_addr <= '0;
            hit1     <= '0;
            vis1     <= 1'b0;
            hs1      <= 1'b1;
            vs1      <= 1'b1;
        end else if (tick) begin
            bg_addr <= vis0 ? bg_off : '0;
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                spr_addr[i*SADDR_W +: SADDR_W] <= addr_c[i];
            end
            hit1 <= hit_c;
            vis1 <= vis0;
            hs1  <= hs0;
            vs1  <= vs0;
        end
    end

    logic [COLOR_W-1:0] pix;
    logic               found;
    logic [COLOR_W-1:0] rgb;

    always_comb begin
        pix   = bg_data ? bg_ink : bg_paper;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (!found && hit1[i] && spr_data[i]) begin
                found = 1'b1;
                pix   = sh_color[i];
            end
        end
        if (!vis1) begin
            pix = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb    <= '0;
            active <= 1'b0;
            hSync  <= 1'b1;
            vSync  <= 1'b1;
        end else if (tick) begin
            rgb    <= pix;
            active <= vis1;
            hSync  <= hs1;
            vSync  <= vs1;
        end
    end

    assign VGA_R = rgb[COLOR_W-1 -: 4];
    assign VGA_G = rgb[COLOR_W-5 -: 4];
    assign VGA_B = rgb[COLOR_W-9 -: 4];

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Bench for vga_sprite_compositor on a shrunken raster: every clock is compared against
// a pixel-position model derived from the clock count since reset.
module tb_vga_sprite_compositor;
    localparam int CD = 3;
    localparam int HA = 48, HFP = 4, HSW = 6, HBP = 6;
    localparam int VA = 24, VFP = 2, VSW = 2, VBP = 3;
    localparam int NS = 2, SW = 8, SH = 6, NF = 3, CW = 12;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int FC = FRAME * CD;
    localparam int SAW = $clog2(SW*SH*NF);
    localparam int BAW = $clog2(HA*VA);

    logic              clk = 1'b0;
    logic              reset;
    logic [NS*10-1:0]  sprite_x;
    logic [NS*9-1:0]   sprite_y;
    logic [NS-1:0]     sprite_en;
    logic [NS*2-1:0]   sprite_frame;
    logic [NS*CW-1:0]  sprite_color;
    logic [CW-1:0]     bg_ink;
    logic [CW-1:0]     bg_paper;
    logic [BAW-1:0]    bg_addr;
    logic              bg_data;
    logic [NS*SAW-1:0] spr_addr;
    logic [NS-1:0]     spr_data;
    logic              hSync, vSync, active, screenEnd;
    logic [3:0]        VGA_R, VGA_G, VGA_B;

    vga_sprite_compositor #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .NUM_SPRITES(NS), .SPRITE_W(SW), .SPRITE_H(SH), .NUM_FRAMES(NF), .COLOR_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_en(sprite_en),
        .sprite_frame(sprite_frame), .sprite_color(sprite_color),
        .bg_ink(bg_ink), .bg_paper(bg_paper),
        .bg_addr(bg_addr), .bg_data(bg_data),
        .spr_addr(spr_addr), .spr_data(spr_data),
        .hSync(hSync), .vSync(vSync),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .active(active), .screenEnd(screenEnd)
    );

    always #5 clk = ~clk;

    bit bg_mem  [1<<BAW];
    bit spr_mem [NS][1<<SAW];

    // Sprite attributes in force for the frame currently on screen, plus the live colours at the last tick.
    int          m_x [NS];
    int          m_y [NS];
    int          m_fr [NS];
    bit          m_en [NS];
    logic [11:0] m_col [NS];
    logic [11:0] m_ink, m_paper;

    int ncyc = 0;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, ncyc);
        end
    endtask

    function automatic bit in_spr(input int i, input int x, input int y);
        return m_en[i] && x >= m_x[i] && x < m_x[i] + SW && y >= m_y[i] && y < m_y[i] + SH;
    endfunction

    function automatic int exp_saddr(input int i, input int x, input int y);
        if (x >= HA || y >= VA || !in_spr(i, x, y)) return 0;
        return m_fr[i]*SW*SH + (y - m_y[i])*SW + (x - m_x[i]);
    endfunction

    function automatic logic [11:0] exp_pix(input int x, input int y);
        for (int i = 0; i < NS; i++) begin
            if (in_spr(i, x, y) && spr_mem[i][exp_saddr(i, x, y)]) return m_col[i];
        end
        return bg_mem[x + HA*y] ? m_ink : m_paper;
    endfunction

    task automatic step();
        bit rst_edge;
        int t, q, x, y;
        logic e_hs, e_vs, e_act, e_se;
        logic [11:0] e_rgb;
        int e_bg;
        rst_edge = reset;
        @(posedge clk);
        #1;
        if (rst_edge) begin
            ncyc = 0;
            for (int i = 0; i < NS; i++) begin
                m_en[i] = 0; m_x[i] = 0; m_y[i] = 0; m_fr[i] = 0; m_col[i] = '0;
            end
        end else begin
            ncyc++;
            if (ncyc % CD == 0) begin
                m_ink = bg_ink;
                m_paper = bg_paper;
            end
            if (ncyc > 1 && (ncyc - 1) % FC == 0) begin
                for (int i = 0; i < NS; i++) begin
                    m_x[i]   = int'(sprite_x[10*i +: 10]);
                    m_y[i]   = int'(sprite_y[9*i +: 9]);
                    m_en[i]  = sprite_en[i];
                    m_fr[i]  = int'(sprite_frame[2*i +: 2]);
                    if (m_fr[i] >= NF) m_fr[i] = 0;
                    m_col[i] = sprite_color[CW*i +: CW];
                end
            end
        end
        bg_data = bg_mem[bg_addr];
        for (int i = 0; i < NS; i++) spr_data[i] = spr_mem[i][spr_addr[i*SAW +: SAW]];
        @(negedge clk);
        t = ncyc / CD;
        e_hs = 1'b1; e_vs = 1'b1; e_act = 1'b0; e_rgb = '0;
        if (t >= 2) begin
            q = (t - 2) % FRAME;
            x = q % HT;
            y = q / HT;
            e_hs  = !(x >= HA + HFP && x < HA + HFP + HSW);
            e_vs  = !(y >= VA + VFP && y < VA + VFP + VSW);
            e_act = (x < HA && y < VA);
            e_rgb = e_act ? exp_pix(x, y) : 12'h000;
        end
        e_se = (ncyc > 0 && ncyc % CD == 0 && t % FRAME == 0);
        chk("hSync", hSync, e_hs);
        chk("vSync", vSync, e_vs);
        chk("active", active, e_act);
        chk("rgb", {VGA_R, VGA_G, VGA_B}, e_rgb);
        chk("screenEnd", screenEnd, e_se);
        e_bg = 0;
        x = 0;
        y = VA;
        if (t >= 1) begin
            q = (t - 1) % FRAME;
            x = q % HT;
            y = q / HT;
            if (x < HA && y < VA) e_bg = x + HA*y;
        end
        chk("bg_addr", bg_addr, e_bg);
        for (int i = 0; i < NS; i++)
            chk($sformatf("spr_addr%0d", i), spr_addr[i*SAW +: SAW], exp_saddr(i, x, y));
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (ncyc < target && guard < 4*FC) begin
            step();
            guard++;
        end
    endtask

    task automatic set_spr(input int i, input int x, input int y, input bit en,
                           input int fr, input logic [11:0] col);
        sprite_x[10*i +: 10]   = 10'(x);
        sprite_y[9*i +: 9]     = 9'(y);
        sprite_en[i]           = en;
        sprite_frame[2*i +: 2] = 2'(fr);
        sprite_color[CW*i +: CW] = col;
    endtask

    task automatic rand_cfg();
        for (int i = 0; i < NS; i++)
            set_spr(i, $urandom_range(0, HA + 4), $urandom_range(0, VA + 2),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3), 12'($urandom));
        bg_ink = 12'($urandom);
        bg_paper = 12'($urandom);
    endtask

    initial begin
        reset = 1'b1;
        sprite_x = '0; sprite_y = '0; sprite_en = '0; sprite_frame = '0; sprite_color = '0;
        bg_ink = 12'h00F; bg_paper = 12'hFFF; bg_data = 1'b0; spr_data = '0;
        m_ink = '0; m_paper = '0;
        for (int a = 0; a < (1<<BAW); a++) bg_mem[a] = ($urandom_range(0, 2) == 0);
        for (int i = 0; i < NS; i++)
            for (int a = 0; a < (1<<SAW); a++) spr_mem[i][a] = ($urandom_range(0, 9) < 7);

        repeat (3) step();
        reset = 1'b0;

        // Frame 1: lone sprite 0, frame 0.
        set_spr(0, 10, 5, 1'b1, 0, 12'h123);
        set_spr(1, 0, 0, 1'b0, 0, 12'hABC);
        run_to(FC + 2);
        // Frame 2: animation frame 2 and an overlapping sprite 1.
        set_spr(0, 10, 5, 1'b1, 2, 12'h123);
        set_spr(1, 12, 7, 1'b1, 1, 12'h456);
        run_to(2*FC + 2);
        // Frame 3: coincident sprites (priority), out-of-range frame, mid-frame move and ink change.
        set_spr(0, 20, 10, 1'b1, 1, 12'h0F0);
        set_spr(1, 20, 10, 1'b1, 3, 12'hF00);
        run_to(2*FC + FC/2);
        set_spr(0, 30, 10, 1'b1, 1, 12'h0F0);
        bg_ink = 12'h5A5;
        run_to(3*FC + FC/2);
        bg_paper = 12'h321;
        run_to(4*FC + 2);
        // Frame 5: right and bottom clipping.
        set_spr(0, HA - 4, VA - 3, 1'b1, 0, 12'h777);
        set_spr(1, HA - 1, 2, 1'b1, 2, 12'h888);
        run_to(5*FC + 2);
        // Frame 6: sprites entirely off-screen.
        set_spr(0, HA, 0, 1'b1, 0, 12'h999);
        set_spr(1, 1020, 510, 1'b1, 0, 12'hAAA);
        run_to(6*FC + 2);
        rand_cfg();
        run_to(7*FC + 2);
        rand_cfg();
        run_to(7*FC + FC/3);
        // Single-clock reset mid-frame: restart from (0,0) with all sprites disabled.
        reset = 1'b1;
        step();
        reset = 1'b0;
        rand_cfg();
        run_to(FC + FC/2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vga_sprite_compositor.md
Name: vga_sprite_compositor

Overview:
- Parametrised next-generation VGA output block.
- Generates 640x480 timing internally from the system clock using a pixel-enable divider. No derived clock.
- Composites a 1-bit background bitmap with NUM_SPRITES independently positioned, animated, coloured 1-bit sprites.
- Sprite positions, frames and enables are frame-synchronous: they are latched only at frame boundaries, so no tearing.
- Sits between game-state registers (CPU-driven positions) and the VGA pins. Bitmap RAMs are external, synchronous read with 1-clk latency.

Parameters:
- CLK_DIV, 4, system clocks per pixel; must be ≥2.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync pulse in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync pulse in lines.
- V_BP, 33, vertical back porch in lines.
- NUM_SPRITES, 2, number of sprite channels.
- SPRITE_W, 60, sprite width in pixels.
- SPRITE_H, 60, sprite height in pixels.
- NUM_FRAMES, 3, animation frames per sprite bitmap.
- COLOR_W, 12, RGB width (4:4:4).
- SADDR_W, clog2(SPRITE_W*SPRITE_H*NUM_FRAMES), sprite RAM address width.
- BADDR_W, clog2(H_ACTIVE*V_ACTIVE), background RAM address width.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high.
- sprite_x  in  NUM_SPRITES*10  left edge of sprite i in bits [10i+9:10i].
- sprite_y  in  NUM_SPRITES*9  top edge of sprite i.
- sprite_en  in  NUM_SPRITES  per-sprite enable.
- sprite_frame  in  NUM_SPRITES*2  animation frame index per sprite.
- sprite_color  in  NUM_SPRITES*COLOR_W  ink colour per sprite.
- bg_ink  in  COLOR_W  colour where background bit = 1.
- bg_paper  in  COLOR_W  colour where background bit = 0.
- bg_addr  out  BADDR_W  background RAM read address.
- bg_data  in  1  background bit, valid 1 clk after bg_addr.
- spr_addr  out  NUM_SPRITES*SADDR_W  per-sprite RAM read address.
- spr_data  in  NUM_SPRITES  per-sprite bit, valid 1 clk after spr_addr.
- hSync  out  1  horizontal sync, active-low.
- vSync  out  1  vertical sync, active-low.
- VGA_R  out  4  red.
- VGA_G  out  4  green.
- VGA_B  out  4  blue.
- active  out  1  high while a visible pixel is being driven, aligned with RGB.
- screenEnd  out  1  one-clk pulse at frame wrap.

Behaviour:

Pixel tick:
- Divider counts 0..CLK_DIV-1. tick = (div == CLK_DIV-1).
- All pixel-domain registers update only on tick.

Counters:
- hcount runs 0..H_ACTIVE+H_FP+H_SYNC+H_BP-1 (799) and wraps.
- vcount increments on hcount wrap and runs 0..524, then wraps.

screenEnd:
- High for exactly one clk, on the tick where (hcount,vcount) goes from (799,524) to (0,0).

Shadow registers:
- sprite_x/y/en/frame/color are latched into shadow registers on the screenEnd cycle only.
- Mid-frame input changes are invisible until the next frame.
- bg_ink and bg_paper are used live.

Hit test and addressing (stage 1):
- Hit test for sprite i: x ≥ sx and x < sx+SPRITE_W, evaluated in 11 bits so no wrap; y is handled likewise in 10 bits; the sprite must also be enabled.
- spr_addr_i = frame*SPRITE_W*SPRITE_H + (y−sy)*SPRITE_W + (x−sx). It is registered.
- When there is no hit, spr_addr_i = 0 and the hit flag is cleared.
- sprite_frame ≥ NUM_FRAMES is treated as frame 0.
- bg_addr = x + H_ACTIVE*y, registered. It is 0 outside the active area.

Compose (stage 2):
- Uses the RAM data returned 1 clk after the stage-1 addresses.
- The lowest-index sprite with hit and spr_data=1 wins and outputs its colour.
- Otherwise the pixel is bg_ink if bg_data=1, else bg_paper.
- Outside the active area the output is 0.

Latency and alignment:
- Pipeline latency is 2 pixel ticks from counter to RGB.
- hSync, vSync and active are delayed by 2 ticks to stay aligned.
- hSync is low for hcount in [656,751]; vSync is low for vcount in [490,491], both before the delay.

Clipping:
- Sprites extending past x=639 or y=479 are clipped with no wrap.
- sx ≥ 640 or sy ≥ 480 gives an invisible sprite.

Reset:
- div, hcount and vcount = 0. Shadow registers = 0, with all sprites disabled.
- Pipeline cleared. hSync=1, vSync=1, RGB=0, active=0, screenEnd=0, bg_addr=0, spr_addr=0.
- Reset mid-frame restarts at (0,0) on the next clk. The first screenEnd follows a full frame later (420000*CLK_DIV clks).

Test Plan:
- Reset, then run 1 line → hSync low for exactly 96*4=384 clks, line period 3200 clks, RGB=0 during blanking, vSync period 525 lines = 1 680 000 clks, screenEnd single-clk pulses exactly that far apart.
- Sprite 0 enabled at (100,200), frame 0, spr_data tied 1, bg_data 0, bg_paper=FFF → pixel (100,200) is sprite_color, (99,200) and (160,200) are FFF; spr_addr at (101,201) = 61. With frame=2, (100,200) → spr_addr 7200.
- Sprites 0 and 1 both at (300,300), colours 0F0 and F00, both data=1 → 0F0 shown. With sprite 0 spr_data=0 → F00 shown.
- Change sprite_x from 100 to 400 mid-frame (vcount=240) → remainder of the frame still drawn at 100; the next frame is drawn at 400.
- Sprite at x=620 → columns 620..639 drawn, no pixels at x=0..39 on the same lines. Sprite at x=700 → nothing drawn.
- Assert reset for 1 clk at vcount=300 → next clk all outputs at reset values, counters (0,0), and no screenEnd until a full frame elapses.
